bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 Parameter GAP_CYCLES, default 0, number of idle cycles inserted after each word; legal range 0..15.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 x  output  1  serial bit stream, registered; feeds the downstream sequence-detector FSM input.
REQ-010 x_valid  output  1  x carries a payload bit this cycle.
REQ-011 word_done  output  1  high during the cycle the last bit of a word is on x.
REQ-012 busy  output  1  high in SHIFT or GAP state.

Function
REQ-013 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into the shift register on that edge.
REQ-014 States SHALL be IDLE, SHIFT and GAP.
REQ-015 in_ready SHALL be 1 in IDLE, and also in SHIFT during the last-bit cycle when GAP_CYCLES=0; otherwise 0.
REQ-016 IDLE transitions: transfer -> SHIFT; no transfer -> IDLE.
REQ-017 SHIFT transitions: hold for exactly WIDTH cycles.
REQ-018 After the last bit of a word, SHIFT SHALL go to GAP if GAP_CYCLES>0.
REQ-019 After the last bit with GAP_CYCLES=0, SHIFT SHALL stay in SHIFT on a concurrent transfer, otherwise go to IDLE.
REQ-020 GAP SHALL hold for exactly GAP_CYCLES cycles, then go to IDLE; in_valid is ignored in GAP.
REQ-021 Latency: the first bit SHALL appear on x with x_valid=1 in the cycle after the transfer edge.
REQ-022 Each bit SHALL be held for one cycle, in order per MSB_FIRST.
REQ-023 When GAP_CYCLES=0 with a continuous in_valid=1, x_valid SHALL stay continuously 1 with no bubble between words.
REQ-024 x SHALL be 0 whenever x_valid=0.
REQ-025 word_done SHALL be 1 for exactly one cycle per word, coincident with the last bit; it is never asserted for a partial word.
REQ-026 The bit counter SHALL be $clog2(WIDTH) bits wide, count 0..WIDTH-1, and wrap to 0 on the last bit without overflow for non-power-of-2 WIDTH.
REQ-027 in_data changes while not transferring SHALL have no effect on x.

Reset
REQ-028 While rst=0 at a rising edge, the next state SHALL be IDLE.
REQ-029 Registers SHALL reset to: x=0, x_valid=0, word_done=0, busy=0, bit counter=0, gap counter=0, shift register=0.
REQ-030 in_ready SHALL be 0 in any cycle where rst=0, and 1 in the first cycle after release.
REQ-031 Reset mid-word SHALL abort the word: no further bits and no word_done; the remaining bits are discarded.

Structure
REQ-032 State encodings (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) SHALL live in a shared constants package, serializer_pkg, reused by the downstream detector bench.
REQ-033 Design SHALL be a single module with no sub-module; the counters are inline.
REQ-034 Encoding 2'd3 SHALL be treated as IDLE, as the default next state.

Verification
REQ-035 Defaults, transfer 8'hB4 -> x = 1,0,1,1,0,1,0,0 on cycles T+1..T+8, x_valid=1 throughout, word_done only at T+8.
REQ-036 MSB_FIRST=0, transfer 8'hB4 -> x = 0,0,1,0,1,1,0,1.
REQ-037 GAP_CYCLES=0, in_valid held high with 8'hFF then 8'h00 -> 16 consecutive x_valid cycles (eight 1s then eight 0s), in_ready high at T+8.
REQ-038 GAP_CYCLES=3, back-to-back requests -> 3 cycles with x_valid=0 and busy=1 between words, second word starting 4 cycles after the first word_done.
REQ-039 Apply rst=0 at bit 4 of 8'hA5, release after 1 cycle -> x=0, x_valid=0, no word_done, in_ready=1 the cycle after release; next word 8'h3C serializes intact.
REQ-040 WIDTH=5, transfer 5'b10011 -> exactly 5 bits 1,0,0,1,1, word_done once, counter wraps cleanly for the next word.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared constants for the bit serializer and the downstream sequence-detector bench.
// Holds the state encoding and the gap-counter sizing.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } serState_t;

  localparam int GAP_CNT_W = 4;
  localparam int MAX_GAP   = 15;

  function automatic logic stateIsBusy(input serState_t s);
    return (s == SHIFT) || (s == GAP);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a valid/ready handshake and
// shifts it out one bit per cycle on x, optionally followed by GAP_CYCLES idle cycles.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  serState_t              state_q, state_d;
  logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
  logic [GAP_CNT_W-1:0]   gapCnt_q, gapCnt_d;
  logic [WIDTH-1:0]       shiftReg_q, shiftReg_d;
  logic                   x_q, x_d;
  logic                   xValid_q, xValid_d;
  logic                   wordDone_q, wordDone_d;
  logic                   readyRaw;
  logic                   load;
  logic                   advance;
  logic                   lastBit;

  assign lastBit = (bitCnt_q == LAST_BIT);

  // Next-state logic; load and advance are decoded first, then applied to the datapath below.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    gapCnt_d   = gapCnt_q;
    shiftReg_d = shiftReg_q;
    x_d        = 1'b0;
    xValid_d   = 1'b0;
    wordDone_d = 1'b0;
    readyRaw   = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;

    case (state_q)
      SHIFT: begin
        if (!lastBit) begin
          advance = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d  = GAP;
          gapCnt_d = '0;
          bitCnt_d = '0;
        end else begin
          readyRaw = 1'b1;
          bitCnt_d = '0;
          if (in_valid) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gapCnt_q == LAST_GAP) begin
          state_d  = IDLE;
          gapCnt_d = '0;
        end else begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end
      default: begin
        readyRaw = 1'b1;
        if (in_valid) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    // The first bit goes straight to x on the transfer edge, so the register keeps the rest.
    if (load) begin
      state_d  = SHIFT;
      bitCnt_d = '0;
      xValid_d = 1'b1;
      if (MSB_FIRST != 0) begin
        x_d        = in_data[WIDTH-1];
        shiftReg_d = in_data << 1;
      end else begin
        x_d        = in_data[0];
        shiftReg_d = in_data >> 1;
      end
    end

    if (advance) begin
      bitCnt_d   = bitCnt_q + 1'b1;
      xValid_d   = 1'b1;
      wordDone_d = (bitCnt_d == LAST_BIT);
      if (MSB_FIRST != 0) begin
        x_d        = shiftReg_q[WIDTH-1];
        shiftReg_d = shiftReg_q << 1;
      end else begin
        x_d        = shiftReg_q[0];
        shiftReg_d = shiftReg_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      gapCnt_q   <= '0;
      shiftReg_q <= '0;
      x_q        <= 1'b0;
      xValid_q   <= 1'b0;
      wordDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      gapCnt_q   <= gapCnt_d;
      shiftReg_q <= shiftReg_d;
      x_q        <= x_d;
      xValid_q   <= xValid_d;
      wordDone_q <= wordDone_d;
    end
  end

  assign in_ready  = readyRaw & rst;
  assign x         = x_q;
  assign x_valid   = xValid_q;
  assign word_done = wordDone_q;
  assign busy      = stateIsBusy(state_q);

endmodule
